// File: rtl/uart_tx_block.sv
// UART transmitter: accepts one byte over valid/ready and sends it LSB-first as
// start bit, DATA_BITS data bits, stop bit, each held for a latched bit period.
module uart_tx_block #(
  parameter int DATA_BITS   = 8,
  parameter int PERIOD_BITS = 14
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic [PERIOD_BITS-1:0] bit_period,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic                   serial_out,
  output logic                   tx_busy,
  output logic                   tx_done
);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [PERIOD_BITS-1:0] period_q, period_d;
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   serial_q, serial_d;
  logic                   done_q, done_d;
  logic                   accept, bit_end;

  assign tx_ready   = (state_q == IDLE);
  assign tx_busy    = (state_q != IDLE);
  assign serial_out = serial_q;
  assign tx_done    = done_q;
  assign accept     = tx_valid && tx_ready;
  // Counter runs 1..P inside a bit; the last cycle of every bit is cnt == P.
  assign bit_end    = (cnt_q == period_q);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    serial_d = serial_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        if (accept) begin
          shift_d  = tx_data;
          period_d = (bit_period < PERIOD_BITS'(2)) ? PERIOD_BITS'(2) : bit_period;
          cnt_d    = PERIOD_BITS'(1);
          serial_d = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        cnt_d = bit_end ? PERIOD_BITS'(1) : cnt_q + PERIOD_BITS'(1);
        if (bit_end) begin
          idx_d    = '0;
          serial_d = shift_q[0];
          state_d  = DATA;
        end
      end
      DATA: begin
        cnt_d = bit_end ? PERIOD_BITS'(1) : cnt_q + PERIOD_BITS'(1);
        if (bit_end) begin
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            shift_d  = shift_q >> 1;
            serial_d = shift_d[0];
            idx_d    = idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        cnt_d = bit_end ? PERIOD_BITS'(1) : cnt_q + PERIOD_BITS'(1);
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        serial_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      period_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      done_q   <= done_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_block.sv
// Directed bench for uart_tx_block: frame timing, back-to-back, busy-ignore,
// period clamp/max and reset behaviour, sampled on the falling edge.
module tb_uart_tx_block;
  localparam int DB = 8;
  localparam int PW = 14;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [PW-1:0] bit_period = '0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, serial_out, tx_busy, tx_done;
  int            pass_cnt = 0;
  int            total_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_block #(.DATA_BITS(DB), .PERIOD_BITS(PW)) dut (
    .clk(clk), .n_rst(n_rst), .bit_period(bit_period), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .serial_out(serial_out),
    .tx_busy(tx_busy), .tx_done(tx_done)
  );

  // Expected line level k cycles after the acceptance edge (k >= 1) inside a frame.
  function automatic logic exp_line(input logic [7:0] d, input int p, input int k);
    int slot;
    slot = (k - 1) / p;
    if (slot == 0) return 1'b0;
    if (slot <= DB) return d[slot-1];
    return 1'b1;
  endfunction

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100)
      $display("FAIL reset_state got %b want 1100", {serial_out, tx_ready, tx_busy, tx_done});
    else pass_cnt++;
    n_rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100)
        $display("FAIL reset_idle k=%0d got %b want 1100", k, {serial_out, tx_ready, tx_busy, tx_done});
      else pass_cnt++;
    end
  endtask

  task automatic test_single_frame();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'hA5; bit_period = 14'd10; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int k = 1; k <= 101; k++) begin
      if (k > 1) @(negedge clk);
      exp = (k <= 100) ? {exp_line(8'hA5, 10, k), 3'b010} : 4'b1101;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL single_frame k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'h00; bit_period = 14'd4; tx_valid = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 83; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 40)      exp = {exp_line(8'h00, 4, k), 3'b010};
      else if (k == 41) exp = 4'b1101;
      else if (k <= 81) exp = {exp_line(8'hFF, 4, k - 41), 3'b010};
      else if (k == 82) exp = 4'b1101;
      else              exp = 4'b1100;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL back_to_back k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
      // Second byte presented only in the done cycle; replaced right after acceptance.
      if (k == 41) tx_data = 8'hFF;
      if (k == 42) begin tx_data = 8'h5A; tx_valid = 1'b0; end
    end
  endtask

  task automatic test_ignore_busy();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'h3C; bit_period = 14'd6; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int k = 1; k <= 70; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 60)      exp = {exp_line(8'h3C, 6, k), 3'b010};
      else if (k == 61) exp = 4'b1101;
      else              exp = 4'b1100;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL ignore_busy k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
      if (k == 20) begin tx_data = 8'hC3; bit_period = 14'd7; tx_valid = 1'b1; end
      if (k == 21) tx_valid = 1'b0;
    end
  endtask

  task automatic test_period_clamp();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'h55; bit_period = 14'd0; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int k = 1; k <= 23; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 20)      exp = {exp_line(8'h55, 2, k), 3'b010};
      else if (k == 21) exp = 4'b1101;
      else              exp = 4'b1100;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL period_clamp k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_period_max();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'h01; bit_period = 14'd16383; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int k = 1; k <= 16384; k++) begin
      if (k > 1) @(negedge clk);
      exp = (k <= 16383) ? 4'b0010 : 4'b1010;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL period_max k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
    end
    // A full max-period frame is far too long to run out; abort it.
    n_rst = 1'b0;
    #1;
    total_cnt++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100)
      $display("FAIL period_max_abort got %b want 1100", {serial_out, tx_ready, tx_busy, tx_done});
    else pass_cnt++;
    @(negedge clk); n_rst = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] exp;
    @(negedge clk); tx_data = 8'h00; bit_period = 14'd5; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    repeat (22) @(negedge clk);
    total_cnt++;
    if ({serial_out, tx_busy} !== 2'b01)
      $display("FAIL mid_frame_pre got %b want 01", {serial_out, tx_busy});
    else pass_cnt++;
    n_rst = 1'b0;
    #1;
    total_cnt++;
    if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100)
      $display("FAIL mid_frame_async got %b want 1100", {serial_out, tx_ready, tx_busy, tx_done});
    else pass_cnt++;
    @(negedge clk); @(negedge clk); n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== 4'b1100)
        $display("FAIL mid_frame_release k=%0d got %b want 1100", k, {serial_out, tx_ready, tx_busy, tx_done});
      else pass_cnt++;
    end
    tx_data = 8'h81; bit_period = 14'd5; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= 50)      exp = {exp_line(8'h81, 5, k), 3'b010};
      else if (k == 51) exp = 4'b1101;
      else              exp = 4'b1100;
      total_cnt++;
      if ({serial_out, tx_ready, tx_busy, tx_done} !== exp)
        $display("FAIL after_reset_frame k=%0d got %b want %b", k, {serial_out, tx_ready, tx_busy, tx_done}, exp);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_ignore_busy();
    test_period_clamp();
    test_period_max();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/uart_tx_block.md
Name: uart_tx_block

Overview:
- Serial transmitter that pairs with the team's UART receive path and the flex_counter-based bit timers.
- Accepts one parallel byte through a valid/ready handshake.
- Serialises it LSB-first as one frame: 1 start bit (0), DATA_BITS data bits, 1 stop bit (1).
- Each bit is held for a programmable number of clocks.
- Sits between the packet/control logic and the chip's serial output pad.

Parameters:
DATA_BITS, 8, number of data bits per frame
PERIOD_BITS, 14, width of bit_period input and internal clock-per-bit counter

Ports:
clk  input  1  system clock, all logic on rising edge
n_rst  input  1  asynchronous active-low reset
bit_period  input  PERIOD_BITS  clocks per serial bit; sampled only at frame acceptance
tx_data  input  DATA_BITS  byte to send; sampled only at frame acceptance
tx_valid  input  1  producer has a byte to send
tx_ready  output  1  block can accept a byte this cycle
serial_out  output  1  serial line, idle high, registered
tx_busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset (async, n_rst=0):
  - serial_out=1, tx_ready=1, tx_busy=0, tx_done=0.
  - State=IDLE; all counters and shift register cleared.
  - Reset mid-frame aborts the frame; serial_out goes high immediately, with no partial stop bit.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_ready=1, tx_busy=0, serial_out=1.
  - Acceptance: tx_valid=1 and tx_ready=1 at an edge, cycle t. Latch tx_data into the shift register and P=max(bit_period,2) into the period register. Go to START.
  - START: serial_out=0 for P cycles. Then go to DATA with bit index 0.
  - DATA: serial_out = shift register LSB for P cycles. Then shift right and increment the bit index. After bit DATA_BITS-1, go to STOP.
  - STOP: serial_out=1 for P cycles. Then go to IDLE.
- Timing, with acceptance edge at end of cycle t (P = period register):
  - Start bit occupies cycles t+1 .. t+P.
  - Data bit i occupies cycles t+1+(i+1)P .. t+(i+2)P.
  - Stop bit occupies cycles t+1+(DATA_BITS+1)P .. t+(DATA_BITS+2)P.
  - Cycle t+1+(DATA_BITS+2)P: state IDLE, tx_done=1 for exactly that cycle, tx_ready=1.
- tx_ready=0 and tx_busy=1 from cycle t+1 until return to IDLE. tx_valid is ignored while busy and no data is lost or queued.
- Back-to-back frames: if tx_valid is held, the next frame is accepted in the IDLE/tx_done cycle. The line therefore sees stop bit + exactly 1 idle-high cycle, then the next start bit.
- Bit timer:
  - Internal counter counts 1..P and wraps to 1 at rollover, with the same rollover semantics as flex_counter.
  - The bit advances on the cycle the counter equals P.
  - Counter clears on acceptance and on return to IDLE.
- bit_period or tx_data changes during a frame have no effect until the next acceptance.
- bit_period values 0 and 1 are treated as 2. The maximum 2^PERIOD_BITS-1 must work without overflow.
- serial_out must be glitch-free: driven directly from a flop, not from combinational decode.

Test Plan:
- Reset: assert n_rst=0 for 3 cycles -> serial_out=1, tx_ready=1, tx_busy=0, tx_done=0. Release with tx_valid=0 for 20 cycles -> outputs unchanged.
- Single frame: bit_period=10, tx_data=0xA5, tx_valid pulse 1 cycle -> 100-cycle sequence 0,1,0,1,0,0,1,0,1,1 (each 10 cycles); tx_done pulses at cycle t+101; tx_busy high cycles t+1..t+100.
- Back-to-back: bit_period=4, tx_valid held high with 0x00 then 0xFF -> frame1 40 cycles, exactly 1 idle-high cycle, frame2 begins; second byte sampled at the tx_done cycle.
- Ignore while busy: during a frame with 0x3C, change tx_data to 0xC3 and bit_period to 7 mid-frame, pulse tx_valid -> frame still 0x3C at original period; no second frame starts.
- Period clamp and max: bit_period=0 with 0x55 -> each bit 2 cycles, frame 20 cycles. bit_period=16383 with 0x01 -> start bit exactly 16383 cycles, no early rollover.
- Reset mid-frame: assert n_rst=0 during data bit 3 -> serial_out=1 asynchronously, tx_ready=1 after release; next accepted frame (0x81, P=5) transmits correctly from its start bit.
